// File: rtl/score_keeper.sv
// score_keeper: debounced push-button scoring with PLAY/OVER win detection for a two-player display.
// Optional macro AUTO_REPEAT_EN adds auto-repeat while a player button is held.
module score_keeper #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WIN_SCORE       = 21,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       CLK50MHZ,
    input  logic       CPU_RESETN,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTNC,
    output logic [7:0] SCORE1,
    output logic [7:0] SCORE2,
    output logic       GAME_OVER,
    output logic [1:0] WINNER
);
    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  WIN_VAL   = 8'(WIN_SCORE);
    localparam logic [7:0]  MAX_SCORE = 8'd99;

    typedef enum logic {PLAY, OVER} state_t;

    logic [2:0] raw;
    logic [2:0] press;          // bit 0 player 1, bit 1 player 2, bit 2 clear

    state_t     state_reg;
    logic [7:0] score1_reg;
    logic [7:0] score2_reg;
    logic       game_over_reg;
    logic [1:0] winner_reg;

    logic [7:0] score1_next;
    logic [7:0] score2_next;
    logic       hit1;
    logic       hit2;

    assign raw = {BTNC, BTNR, BTNL};

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'd16777215 ||
        WIN_SCORE > 99 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("score_keeper: parameter out of range");
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic        sync_a_reg;
            logic        sync_b_reg;
            logic        deb_reg;
            logic        deb_prev_reg;
            logic        edge_reg;
            logic [23:0] cnt_reg;

            // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge CLK50MHZ or negedge CPU_RESETN) begin
                if (!CPU_RESETN) begin
                    sync_a_reg   <= 1'b0;
                    sync_b_reg   <= 1'b0;
                    deb_reg      <= 1'b0;
                    deb_prev_reg <= 1'b0;
                    edge_reg     <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync_a_reg   <= raw[gi];
                    sync_b_reg   <= sync_a_reg;
                    deb_prev_reg <= deb_reg;
                    edge_reg     <= deb_reg & ~deb_prev_reg;
                    if (sync_b_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        deb_reg <= sync_b_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 24'd1;
                    end
                end
            end

`ifdef AUTO_REPEAT_EN
            if (gi < 2) begin : g_rpt
                localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
                localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

                logic [RPT_W-1:0] rpt_cnt_reg;
                logic             rpt_reg;

                // Gating on both d and d_prev puts the first repeat a full period after the edge pulse.
                always_ff @(posedge CLK50MHZ or negedge CPU_RESETN) begin
                    if (!CPU_RESETN) begin
                        rpt_cnt_reg <= '0;
                        rpt_reg     <= 1'b0;
                    end else if (!(deb_reg && deb_prev_reg)) begin
                        rpt_cnt_reg <= '0;
                        rpt_reg     <= 1'b0;
                    end else if (rpt_cnt_reg == RPT_LAST) begin
                        rpt_cnt_reg <= '0;
                        rpt_reg     <= 1'b1;
                    end else begin
                        rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
                        rpt_reg     <= 1'b0;
                    end
                end

                assign press[gi] = edge_reg | rpt_reg;
            end else begin : g_no_rpt
                assign press[gi] = edge_reg;
            end
`else
            assign press[gi] = edge_reg;
`endif
        end
    endgenerate

    always_comb begin
        score1_next = score1_reg;
        score2_next = score2_reg;
        hit1        = 1'b0;
        hit2        = 1'b0;
        if (press[0] && score1_reg != MAX_SCORE) begin
            score1_next = score1_reg + 8'd1;
            hit1        = (WIN_SCORE != 0) && (score1_next == WIN_VAL);
        end
        if (press[1] && score2_reg != MAX_SCORE) begin
            score2_next = score2_reg + 8'd1;
            hit2        = (WIN_SCORE != 0) && (score2_next == WIN_VAL);
        end
    end

    always_ff @(posedge CLK50MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg     <= PLAY;
            score1_reg    <= '0;
            score2_reg    <= '0;
            game_over_reg <= 1'b0;
            winner_reg    <= 2'b00;
        end else begin
            case (state_reg)
                PLAY: begin
                    if (press[2]) begin
                        score1_reg <= '0;
                        score2_reg <= '0;
                        winner_reg <= 2'b00;
                    end else begin
                        score1_reg <= score1_next;
                        score2_reg <= score2_next;
                        if (hit1 || hit2) begin
                            state_reg     <= OVER;
                            game_over_reg <= 1'b1;
                            winner_reg    <= {hit2, hit1};
                        end
                    end
                end
                OVER: begin
                    if (press[2]) begin
                        state_reg     <= PLAY;
                        score1_reg    <= '0;
                        score2_reg    <= '0;
                        game_over_reg <= 1'b0;
                        winner_reg    <= 2'b00;
                    end
                end
                default: state_reg <= PLAY;
            endcase
        end
    end

    assign SCORE1    = score1_reg;
    assign SCORE2    = score2_reg;
    assign GAME_OVER = game_over_reg;
    assign WINNER    = winner_reg;
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream stage of the two-digit-pair seven-segment display driver.
- Turns raw player push-buttons into two binary scores (0..99), one per 8-bit half of the display's 16-bit value input: SCORE1 drives the upper byte, SCORE2 the lower byte.
- Debounces and edge-detects each button, keeps the scores, and runs a PLAY/OVER game state machine with win detection.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized input must differ from its debounced level before the level flips (10 ms at 50 MHz); legal range 2..2^24-1.
- WIN_SCORE, 21, score that ends the game; 0 disables win detection (free-count mode); legal range 0..99.
- REPEAT_CYCLES, 25000000, auto-repeat period in cycles; used only when AUTO_REPEAT_EN is defined.

Ports:
- CLK50MHZ  input  1  system clock, 50 MHz, all flops on the rising edge.
- CPU_RESETN  input  1  asynchronous active-low reset.
- BTNL  input  1  raw, asynchronous player-1 increment button, active-high.
- BTNR  input  1  raw, asynchronous player-2 increment button, active-high.
- BTNC  input  1  raw, asynchronous clear/new-game button, active-high.
- SCORE1  output  8  player-1 score, binary 0..99, registered.
- SCORE2  output  8  player-2 score, binary 0..99, registered.
- GAME_OVER  output  1  high while in state OVER.
- WINNER  output  2  00 none, 01 player 1, 10 player 2, 11 tie.

Behaviour:
- Reset: CPU_RESETN low asynchronously clears every flop. SCORE1=0, SCORE2=0, GAME_OVER=0, WINNER=00, state=PLAY, all debounced levels 0, all counters 0. A reset asserted mid-debounce or mid-game discards all progress.
- Each button has its own conditioning path:
  - 2-flop synchronizer producing s.
  - Debounced level d and a 24-bit counter c.
  - If s==d, c<=0. Otherwise c<=c+1, and when c==DEBOUNCE_CYCLES-1, d<=s and c<=0.
  - Press pulse p<=d & ~d_prev, registered, exactly one cycle wide.
- Latency: a clean rising raw input first sampled high at edge 0 updates the score register at edge DEBOUNCE_CYCLES+3. A glitch shorter than DEBOUNCE_CYCLES cycles is rejected. Release is debounced identically and produces no pulse.
- Holding a button produces exactly one press.
- State PLAY:
  - Clear press: SCORE1=SCORE2=0, WINNER=00. Clear has priority over same-cycle increments.
  - Otherwise p1 increments SCORE1 and p2 increments SCORE2. Both may increment in the same cycle.
  - Increments saturate at 99; a press at 99 leaves the score unchanged.
  - If WIN_SCORE!=0 and a new score equals WIN_SCORE, go to OVER on that same edge. WINNER=01, 10, or 11 when both reach it on the same edge. GAME_OVER and the final scores become visible together.
- State OVER:
  - Increment presses are ignored and scores are frozen.
  - Clear press zeroes the scores, sets WINNER=00, GAME_OVER=0, state=PLAY.
- Outputs are plain registers with no combinational path from any input.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While a player's debounced level stays high in PLAY, an extra press pulse is generated every REPEAT_CYCLES cycles.
  - The first repeat comes REPEAT_CYCLES cycles after the edge pulse; the repeat counter clears when the level drops.
  - Clear never repeats.
  - Saturation and win rules apply unchanged.
- Undefined: one press per debounced rising edge only, and no repeat counters are synthesized.

Test Plan (DEBOUNCE_CYCLES=4, WIN_SCORE=3, REPEAT_CYCLES=8):
- Reset, then BTNL held high 20 cycles -> SCORE1 goes 0->1 exactly 7 edges after first high sample and stays 1; SCORE2=0, GAME_OVER=0.
- BTNR pulses high 3 cycles, low 3, high 3 -> no score change. Then held 10 cycles -> SCORE2=1.
- Three clean BTNL presses -> SCORE1=3, GAME_OVER=1, WINNER=01 on the same edge. A fourth BTNL press leaves SCORE1=3. BTNC press -> 0/0, GAME_OVER=0, WINNER=00.
- Scores at 2/2, then BTNL and BTNR rising on the same cycle -> 3/3, WINNER=11. Separately, BTNC and BTNL debounced together in PLAY at 1/0 -> 0/0.
- WIN_SCORE=0 override, 101 BTNR presses -> SCORE2 saturates at 99, GAME_OVER stays 0. CPU_RESETN pulsed low mid-debounce -> all outputs 0 immediately, with no press pulse afterwards.
- AUTO_REPEAT_EN defined, BTNL held 4+3+8*3 cycles -> SCORE1 reaches 3, GAME_OVER=1. Undefined, same stimulus -> SCORE1=1.
